dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 21 ++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared widths, defaults and FSM state type for the data-memory responder.
package dmem_responder_pkg;

   localparam int unsigned DMEM_DATA_W    = 32;
   localparam int unsigned DMEM_ADDR_W    = 16;
   localparam int unsigned DMEM_DEPTH_DEF = 256;
   localparam int unsigned DMEM_WAIT_DEF  = 2;
   localparam int unsigned DMEM_CNT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   // Index width for a DEPTH-word array; a single-word array still needs one bit.
   function automatic int unsigned dmem_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, contents never reset.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
   localparam int unsigned AW   = dmem_aw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   i_we,
   input  logic [AW-1:0]          i_waddr,
   input  logic [DMEM_DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]          i_raddr,
   output logic [DMEM_DATA_W-1:0] o_rdata
);

   logic [DMEM_DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one access in IDLE, waits
// WAIT_CYCLES, then returns a registered one-cycle ack with data and range flag.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH       = DMEM_DEPTH_DEF,
   parameter int unsigned WAIT_CYCLES = DMEM_WAIT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic                   we,
   input  logic [DMEM_ADDR_W-1:0] addr,
   input  logic [DMEM_DATA_W-1:0] wdata,
   output logic [DMEM_DATA_W-1:0] rdata,
   output logic                   ack,
   output logic                   err,
   output logic                   busy
);

   localparam int unsigned AW = dmem_aw(DEPTH);
   localparam logic [DMEM_CNT_W-1:0] WAIT_LD = DMEM_CNT_W'(WAIT_CYCLES);

   dmem_state_t            r_state;
   logic [DMEM_CNT_W-1:0]  r_cnt;
   logic                   r_we;
   logic [DMEM_ADDR_W-1:0] r_addr;
   logic [DMEM_DATA_W-1:0] r_wdata;
   logic                   r_ack;
   logic                   r_err;
   logic                   r_busy;
   logic [DMEM_DATA_W-1:0] r_rdata;

   logic                   w_sel_we;
   logic [DMEM_ADDR_W-1:0] w_sel_addr;
   logic [DMEM_DATA_W-1:0] w_sel_wdata;
   logic                   w_in_range;
   logic                   w_resp_err;
   logic [DMEM_DATA_W-1:0] w_resp_rdata;
   logic [DMEM_DATA_W-1:0] w_mem_rdata;
   logic                   w_mem_we;

   // Response payload is registered on the edge entering RESP; with zero wait
   // that edge is the accept edge, so the live request is used in IDLE.
   always_comb begin
      w_sel_we    = r_we;
      w_sel_addr  = r_addr;
      w_sel_wdata = r_wdata;
      if (r_state == ST_IDLE) begin
         w_sel_we    = we;
         w_sel_addr  = addr;
         w_sel_wdata = wdata;
      end
      w_in_range   = (32'(w_sel_addr) < DEPTH);
      w_resp_err   = !w_in_range;
      w_resp_rdata = '0;
      if (w_in_range) begin
         w_resp_rdata = w_sel_we ? w_sel_wdata : w_mem_rdata;
      end
   end

   assign w_mem_we = (r_state == ST_RESP) && r_we && w_in_range;

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_waddr (r_addr[AW-1:0]),
      .i_wdata (r_wdata),
      .i_raddr (w_sel_addr[AW-1:0]),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_busy  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     r_cnt   <= '0;
                     r_state <= ST_RESP;
                     r_ack   <= 1'b1;
                     r_err   <= w_resp_err;
                     r_rdata <= w_resp_rdata;
                  end else begin
                     r_cnt   <= WAIT_LD;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == DMEM_CNT_W'(1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_RESP;
                  r_ack   <= 1'b1;
                  r_err   <= w_resp_err;
                  r_rdata <= w_resp_rdata;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rdata = r_rdata;
   assign ack   = r_ack;
   assign err   = r_err;
   assign busy  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every
// cycle against a timestamp-based transaction model, plus directed scenarios.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int W0    = 2;
   localparam int W1    = 0;

   logic        clk;
   logic        rst   [2];
   logic        req   [2];
   logic        we    [2];
   logic [15:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ack   [2];
   logic        err   [2];
   logic        busy  [2];

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Model state: memory image, pending transaction and its timestamps.
   logic [31:0] mem_m   [2][DEPTH];
   bit          known   [2][DEPTH];
   bit          act     [2];
   int          resp_e  [2];
   bit          p_we    [2];
   bit          p_err   [2];
   bit          p_known [2];
   logic [15:0] p_addr  [2];
   logic [31:0] p_wdata [2];
   logic [31:0] p_rdata [2];
   bit          e_ack   [2];
   bit          e_busy  [2];
   bit          e_err   [2];
   logic [31:0] e_rdata [2];

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fails++;
         $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, act_v, exp_v);
      end
   endtask

   function automatic int wait_of(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   // Edge-level view: accept at edge A, ack visible after edge A+W,
   // write commits and block frees at edge A+W+1.
   task automatic model_step(input int i);
      if (!rst[i]) begin
         act[i] = 0;
      end else if (act[i]) begin
         if (cyc == resp_e[i] + 1) begin
            if (p_we[i] && !p_err[i]) begin
               mem_m[i][p_addr[i][7:0]] = p_wdata[i];
               known[i][p_addr[i][7:0]] = 1;
            end
            act[i] = 0;
         end
      end else if (req[i]) begin
         act[i]     = 1;
         resp_e[i]  = cyc + wait_of(i);
         p_we[i]    = we[i];
         p_addr[i]  = addr[i];
         p_wdata[i] = wdata[i];
         p_err[i]   = (int'(addr[i]) >= DEPTH);
         if (p_err[i]) begin
            p_rdata[i] = '0;
            p_known[i] = 1;
         end else if (p_we[i]) begin
            p_rdata[i] = wdata[i];
            p_known[i] = 1;
         end else begin
            p_rdata[i] = mem_m[i][addr[i][7:0]];
            p_known[i] = known[i][addr[i][7:0]];
         end
      end
      e_busy[i]  = act[i];
      e_ack[i]   = act[i] && (cyc == resp_e[i]);
      e_err[i]   = e_ack[i] && p_err[i];
      e_rdata[i] = e_ack[i] ? p_rdata[i] : '0;
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
      cyc++;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("cyc_ack", i, 32'(ack[i]), 32'(e_ack[i]));
         chk("cyc_busy", i, 32'(busy[i]), 32'(e_busy[i]));
         chk("cyc_err", i, 32'(err[i]), 32'(e_err[i]));
         if (!(e_ack[i] && !p_known[i])) chk("cyc_rdata", i, rdata[i], e_rdata[i]);
      end
   end

   task automatic txn(input int i, input bit w, input logic [15:0] a, input logic [31:0] d,
                      input bit churn, output logic [31:0] rd, output bit er, output int lat);
      @(negedge clk);
      req[i] = 1; we[i] = w; addr[i] = a; wdata[i] = d;
      @(posedge clk);
      lat = 0; rd = '0; er = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req[i] = 0;
            if (churn) begin
               addr[i] = 16'h0020; we[i] = 1; wdata[i] = '1;
            end
         end
         if (ack[i]) begin
            lat = k; rd = rdata[i]; er = err[i];
         end
      end
      chk("ack_seen", i, 32'(lat != 0), 32'd1);
   endtask

   task automatic b2b(input int i, input int exp_space);
      int n, last;
      n = 0; last = 0;
      @(negedge clk);
      req[i] = 1; we[i] = 0; addr[i] = 16'h0010;
      for (int k = 1; k <= 60 && n < 3; k++) begin
         @(negedge clk);
         if (ack[i]) begin
            if (n > 0) chk("b2b_space", i, 32'(k - last), 32'(exp_space));
            last = k;
            n++;
         end
      end
      req[i] = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (ack[i]) n++;
      end
      chk("b2b_acks", i, 32'(n), 32'd3);
   endtask

   task automatic rand_suite(input int i, input int n);
      logic [31:0] rd;
      bit er;
      int lat, a;
      for (int k = 0; k < n; k++) begin
         a = $urandom_range(0, 31);
         txn(i, 1'($urandom_range(0, 1)), (a < 16) ? 16'(a) : 16'(32'h00F0 + a),
             32'($urandom), 1'($urandom_range(0, 1)), rd, er, lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] rd;
      bit er;
      int lat;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1; req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0;
         act[i] = 0; resp_e[i] = 0;
      end
      #1;
      rst[0] = 0; rst[1] = 0;
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ack", i, 32'(ack[i]), 32'd0);
         chk("rst_busy", i, 32'(busy[i]), 32'd0);
         chk("rst_err", i, 32'(err[i]), 32'd0);
         chk("rst_rdata", i, rdata[i], 32'd0);
      end
      @(negedge clk);
      rst[0] = 1;
      repeat (2) @(negedge clk);

      // Two wait states.
      txn(0, 1, 16'h0010, 32'hDEADBEEF, 0, rd, er, lat);
      chk("wr_lat", 0, 32'(lat), 32'd3);
      chk("wr_rdata", 0, rd, 32'hDEADBEEF);
      chk("wr_err", 0, 32'(er), 32'd0);
      txn(0, 0, 16'h0010, 32'h0, 0, rd, er, lat);
      chk("rd_lat", 0, 32'(lat), 32'd3);
      chk("rd_rdata", 0, rd, 32'hDEADBEEF);
      chk("rd_err", 0, 32'(er), 32'd0);

      txn(0, 1, 16'h0000, 32'h0000AAAA, 0, rd, er, lat);
      txn(0, 1, 16'h0100, 32'h12345678, 0, rd, er, lat);
      chk("oor_lat", 0, 32'(lat), 32'd3);
      chk("oor_err", 0, 32'(er), 32'd1);
      chk("oor_rdata", 0, rd, 32'd0);
      txn(0, 0, 16'h0000, 32'h0, 0, rd, er, lat);
      chk("oor_keep0", 0, rd, 32'h0000AAAA);

      txn(0, 1, 16'h0020, 32'h20202020, 0, rd, er, lat);
      txn(0, 0, 16'h0010, 32'h0, 1, rd, er, lat);
      chk("churn_rdata", 0, rd, 32'hDEADBEEF);
      chk("churn_err", 0, 32'(er), 32'd0);
      txn(0, 0, 16'h0020, 32'h0, 0, rd, er, lat);
      chk("churn_keep20", 0, rd, 32'h20202020);

      txn(0, 1, 16'h0005, 32'h0, 0, rd, er, lat);
      @(negedge clk);
      req[0] = 1; we[0] = 1; addr[0] = 16'h0005; wdata[0] = 32'hCAFEF00D;
      @(negedge clk);
      req[0] = 0;
      #2;
      rst[0] = 0;
      #1;
      chk("abort_busy", 0, 32'(busy[0]), 32'd0);
      chk("abort_ack", 0, 32'(ack[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst[0] = 1;
      txn(0, 0, 16'h0005, 32'h0, 0, rd, er, lat);
      chk("abort_rdata", 0, rd, 32'h0);

      b2b(0, W0 + 2);
      rand_suite(0, 40);

      // Zero wait states.
      @(negedge clk);
      rst[1] = 1;
      repeat (2) @(negedge clk);
      txn(1, 1, 16'h0000, 32'h00000001, 0, rd, er, lat);
      chk("z_wr_lat", 1, 32'(lat), 32'd1);
      txn(1, 0, 16'h0000, 32'h0, 0, rd, er, lat);
      chk("z_rd_lat", 1, 32'(lat), 32'd1);
      chk("z_rd_rdata", 1, rd, 32'h00000001);
      b2b(1, W1 + 2);
      rand_suite(1, 40);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
